// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, control word, x0.
package pipe_pkg;

  localparam logic [4:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic id_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freeze;
  } ctrl_t;

  // A load in EX feeds a register the ID instruction reads; x0 never creates a hazard.
  function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic use1, input logic use2,
                                    input logic [4:0] rd, input logic memread);
    return memread && (rd != X0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clr)
      value <= '0;
    else if (inc && value != {W{1'b1}})
      value <= value + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory freeze, redirect
// flush and load-use bubble, with a sticky memory timeout and saturating counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             id_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t        state;
  ctrl_t         ctrl;
  logic          lu;
  logic          freeze;
  logic          stall_go;
  logic          redirect_go;
  logic [TW-1:0] wait_cnt;

  // Freeze wins over everything; a redirect held in the frozen EX stage waits for it.
  always_comb begin
    lu          = load_use(id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread);
    freeze      = !mem_ready && ((state == MEM_WAIT) || (state == RUN && mem_req));
    redirect_go = !freeze && ex_redirect;
    stall_go    = !freeze && !ex_redirect && lu;
    ctrl        = '0;
    if (reset) begin
      ctrl = '0;
    end else if (freeze) begin
      ctrl.pipe_freeze = 1'b1;
    end else if (ex_redirect) begin
      ctrl.pc_we      = 1'b1;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (lu) begin
      ctrl.id_bubble = 1'b1;
    end else begin
      ctrl.pc_we   = 1'b1;
      ctrl.ifid_we = 1'b1;
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign id_bubble   = ctrl.id_bubble;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign pipe_freeze = ctrl.pipe_freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready)
            state <= MEM_WAIT;
          else if (ex_redirect)
            state <= REDIRECT;
          else
            state <= RUN;
        end
        MEM_WAIT: state <= mem_ready ? RUN : MEM_WAIT;
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Wait-cycle counter only lives while in MEM_WAIT; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == MEM_WAIT) begin
      if (int'(wait_cnt) < MEM_TIMEOUT)
        wait_cnt <= wait_cnt + TW'(1);
      if (int'(wait_cnt) + 1 >= MEM_TIMEOUT)
        mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall_go),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (freeze),
    .value (freeze_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (redirect_go),
    .value (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, all
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 3;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_req, mem_ready;
  logic          pc_we, ifid_we, id_bubble, ifid_flush, idex_flush, pipe_freeze, mem_timeout;
  logic [CW-1:0] stall_cnt, freeze_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: memory access outstanding, one cycle after a redirect, counters.
  bit m_wait, m_redir, m_flag;
  int m_wait_cycles, m_stall, m_freeze, m_flush;
  bit e_pc_we, e_ifid_we, e_bubble, e_ifid_flush, e_idex_flush, e_freeze;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .id_bubble   (id_bubble),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .pipe_freeze (pipe_freeze),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .freeze_cnt  (freeze_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit u1, input bit u2, input logic [4:0] rd,
                               input bit mrd, input bit redir, input bit mreq, input bit mrdy);
    reset       = rst;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    ex_rd       = rd;
    ex_memread  = mrd;
    ex_redirect = redir;
    mem_req     = mreq;
    mem_ready   = mrdy;
  endtask

  function automatic int satInc(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  function automatic void predict();
    bit hazard, frz;
    hazard = ex_memread && ex_rd != 5'd0 &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    frz = !mem_ready && (m_wait || (!m_redir && mem_req));
    {e_pc_we, e_ifid_we, e_bubble, e_ifid_flush, e_idex_flush, e_freeze} = '0;
    if (reset) begin
    end else if (frz) begin
      e_freeze = 1'b1;
    end else if (ex_redirect) begin
      e_pc_we = 1'b1; e_ifid_flush = 1'b1; e_idex_flush = 1'b1;
    end else if (hazard) begin
      e_bubble = 1'b1;
    end else begin
      e_pc_we = 1'b1; e_ifid_we = 1'b1;
    end
  endfunction

  function automatic void modelAdvance();
    bit next_wait, next_redir;
    if (reset) begin
      m_wait = 0; m_redir = 0; m_flag = 0;
      m_wait_cycles = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
    end else begin
      if (m_wait) begin
        m_wait_cycles++;
        if (m_wait_cycles >= TIMEOUT) m_flag = 1;
      end else begin
        m_wait_cycles = 0;
      end
      if (e_bubble)     m_stall  = satInc(m_stall);
      if (e_freeze)     m_freeze = satInc(m_freeze);
      if (e_ifid_flush) m_flush  = satInc(m_flush);
      next_wait  = m_wait ? !mem_ready : (!m_redir && mem_req && !mem_ready);
      next_redir = !m_wait && !m_redir && !(mem_req && !mem_ready) && ex_redirect;
      m_wait  = next_wait;
      m_redir = next_redir;
    end
  endfunction

  task automatic checkOutput(input string tag);
    predict();
    checkOne({tag, ".pc_we"},       32'(pc_we),       32'(e_pc_we));
    checkOne({tag, ".ifid_we"},     32'(ifid_we),     32'(e_ifid_we));
    checkOne({tag, ".id_bubble"},   32'(id_bubble),   32'(e_bubble));
    checkOne({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_ifid_flush));
    checkOne({tag, ".idex_flush"},  32'(idex_flush),  32'(e_idex_flush));
    checkOne({tag, ".pipe_freeze"}, 32'(pipe_freeze), 32'(e_freeze));
    checkOne({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_flag));
    checkOne({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_stall));
    checkOne({tag, ".freeze_cnt"},  32'(freeze_cnt),  32'(m_freeze));
    checkOne({tag, ".flush_cnt"},   32'(flush_cnt),   32'(m_flush));
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
  endtask

  initial begin
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    cycle("reset0");
    cycle("reset1");
    checkOne("reset_stall_cnt", 32'(stall_cnt), 32'd0);

    idle();
    cycle("run_idle");

    // Load-use on rs1, then the same pattern with x0 as destination.
    applyStimulus(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1);
    cycle("lu_rs1");
    idle();
    cycle("lu_after");
    checkOne("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    applyStimulus(0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 1);
    cycle("lu_x0");
    idle();
    cycle("lu_x0_after");
    checkOne("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);

    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1);
    cycle("redirect");
    idle();
    cycle("redirect_after");
    checkOne("redirect_flush_cnt", 32'(flush_cnt), 32'd1);

    applyStimulus(0, 5'd5, 5'd7, 1, 1, 5'd7, 1, 1, 0, 1);
    cycle("redir_lu");
    idle();
    cycle("redir_lu_after");
    checkOne("redir_lu_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOne("redir_lu_flush_cnt", 32'(flush_cnt), 32'd2);

    // Three wait cycles with a redirect held in EX, applied when memory completes.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
      cycle($sformatf("memwait%0d", i));
    end
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1);
    cycle("memwait_ready");
    idle();
    cycle("memwait_after");
    checkOne("memwait_freeze_cnt", 32'(freeze_cnt), 32'd3);
    checkOne("memwait_flush_cnt",  32'(flush_cnt),  32'd3);
    checkOne("memwait_no_timeout", 32'(mem_timeout), 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      cycle($sformatf("timeout%0d", i));
    end
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
    cycle("timeout_ready");
    idle();
    cycle("timeout_after");
    checkOne("timeout_sticky", 32'(mem_timeout), 32'd1);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
      cycle($sformatf("midwait%0d", i));
    end
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    cycle("midwait_reset");
    idle();
    cycle("midwait_run");
    checkOne("midwait_flag_clr",   32'(mem_timeout), 32'd0);
    checkOne("midwait_freeze_clr", 32'(freeze_cnt),  32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 5'd3, 5'd9, 1, 1, 5'd9, 1, 0, 0, 1);
      cycle($sformatf("sat%0d", i));
    end
    idle();
    cycle("sat_after");
    checkOne("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0),
                    m_redir ? 1'b0 : ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) != 0));
      cycle($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. Each cycle it decides whether the PC and IF/ID register advance, whether the decode stage injects a bubble into ID/EX, and whether IF/ID and ID/EX are flushed. Inputs are load-use hazards, EX-stage branch/jump redirects and data-memory wait states. It replaces per-stage ad-hoc stall logic and adds saturating performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64: consecutive MEM_WAIT cycles before `mem_timeout` latches.
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch / jal / jalr mispredict; PC must be redirected
- mem_req  in  1  MEM stage is issuing a load or store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC register load enable
- ifid_we  out  1  IF/ID register load enable
- id_bubble  out  1  force decode control word to zero (drives InDecode `stall`)
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  clear ID/EX to NOP (drives InDecode `flush`)
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  load-use stall cycles
- freeze_cnt  out  CNT_W  memory-freeze cycles
- flush_cnt  out  CNT_W  redirect events

## Operation
- Hazard `lu` = ex_memread && ex_rd != 0 && ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2)).
- FSM states:
  - RUN: normal flow.
  - MEM_WAIT: memory pending.
  - REDIRECT: one cycle after a redirect.
- RUN -> MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT stays while !mem_ready.
  - MEM_WAIT -> RUN on mem_ready.
- RUN -> REDIRECT on ex_redirect when not entering MEM_WAIT.
  - REDIRECT -> RUN unconditionally.
- Priority, highest first, evaluated each cycle:
  - freeze: state MEM_WAIT, or RUN with mem_req && !mem_ready. pc_we=0, ifid_we=0, pipe_freeze=1. No flush, no bubble. ex_redirect is held by the frozen EX stage and handled after the freeze.
  - redirect: ex_redirect. pc_we=1, ifid_flush=1, idex_flush=1. lu is ignored because its instruction is squashed.
  - load-use: lu. pc_we=0, ifid_we=0, id_bubble=1.
  - otherwise: pc_we=1, ifid_we=1, all others 0.
- In REDIRECT the ID instruction was just flushed. lu is still evaluated normally.
- Outputs are combinational from state and inputs (Mealy); only state and counters are registered.
- Timeout counter:
  - Counts cycles spent in MEM_WAIT and clears on leaving it.
  - When it reaches MEM_TIMEOUT, mem_timeout sets. It stays set until reset.
  - The FSM keeps waiting after timeout.
- Performance counters:
  - stall_cnt increments on each load-use stall cycle.
  - freeze_cnt increments on each freeze cycle.
  - flush_cnt increments on each cycle redirect is applied.
  - All saturate at 2^CNT_W−1; there is no wrap-around.

## Timing
- Reset: state RUN; counters 0; mem_timeout 0. During reset pc_we=0 and ifid_we=0, all other outputs 0.
- Load-use stall is exactly 1 cycle: the next cycle the load is in MEM, so lu is false.
- Redirect flush takes effect at the same clock edge the new PC loads; 2 wrong-path instructions are killed.
- A freeze lasts exactly as many cycles as mem_ready stays low. The edge where mem_ready=1 is the first advancing edge.
- Reset asserted mid-MEM_WAIT returns to RUN next edge. The timeout counter clears; counters clear.

## Structure
- Shared package `pipe_pkg`: FSM state enum, ctrl-output struct, x0 constant.
- One sub-module `sat_counter` (parameter W; inc, clr, value), instantiated three times.
- `Hazard_detection_unit` is superseded by the `lu` term inside this block.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_we=0, ifid_we=0, id_bubble=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Redirect: ex_redirect=1 in RUN -> ifid_flush=idex_flush=1, pc_we=1 that cycle; state REDIRECT next; flush_cnt=1.
- Redirect + load-use same cycle -> flush only, id_bubble=0, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 for 3 cycles; freeze_cnt=3; redirect asserted during the freeze is applied on the first cycle after.
- Timeout: MEM_TIMEOUT=4, mem_ready low 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready; reset mid-wait -> RUN, flag 0, counters 0.
- Saturation: CNT_W=3, 10 stall cycles -> stall_cnt holds 7.
